lru_unit: RTL and testbench

//  Per-set true-LRU replacement tracker for a set-associative cache.

---
 rtl/lru_unit.sv | 94 +++++++++
 tb/tb_lru_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lru_unit.sv
// lru_unit: per-set true-LRU age tracker with combinational victim read.
// Optional invalidate port pair enabled by defining LRU_INVALIDATE_EN.
module lru_unit #(
  parameter  int SET           = 8,
  parameter  int ASSOCIATIVITY = 4,
  localparam int LRU_WIDTH     = $clog2(ASSOCIATIVITY),
  localparam int IDX_WIDTH     = (SET > 1) ? $clog2(SET) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] index_in,
  input  logic [LRU_WIDTH-1:0] mru_in,
  input  logic                 load_in,
`ifdef LRU_INVALIDATE_EN
  input  logic                 inv_in,
  input  logic [LRU_WIDTH-1:0] inv_way,
`endif
  output logic [LRU_WIDTH-1:0] lru_out
);

  localparam logic [LRU_WIDTH-1:0] AGE_MAX =
    LRU_WIDTH'(ASSOCIATIVITY - 1);

  logic [LRU_WIDTH-1:0] age_q [SET][ASSOCIATIVITY];
  logic [LRU_WIDTH-1:0] cur   [ASSOCIATIVITY];
  logic [LRU_WIDTH-1:0] set_d [ASSOCIATIVITY];
  logic [LRU_WIDTH-1:0] a_mru;
  logic                 wr_en;
`ifdef LRU_INVALIDATE_EN
  logic [LRU_WIDTH-1:0] a_inv;
`endif

  // Select the ages of the indexed set.
  always_comb begin
    cur = age_q[0];
    for (int s = 0; s < SET; s++) begin
      if (IDX_WIDTH'(s) == index_in) cur = age_q[s];
    end
  end

  // Victim is the way holding the oldest age.
  always_comb begin
    lru_out = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (cur[w] == AGE_MAX) lru_out = LRU_WIDTH'(w);
    end
  end

  // Next ages for the indexed set; load beats invalidate.
  always_comb begin
    set_d = cur;
    wr_en = 1'b0;
    a_mru = cur[mru_in];
`ifdef LRU_INVALIDATE_EN
    a_inv = cur[inv_way];
`endif
    if (load_in) begin
      wr_en = 1'b1;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
        if (LRU_WIDTH'(w) == mru_in) set_d[w] = '0;
        else if (cur[w] < a_mru)     set_d[w] = cur[w] + 1'b1;
      end
    end
`ifdef LRU_INVALIDATE_EN
    else if (inv_in) begin
      wr_en = 1'b1;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
        if (LRU_WIDTH'(w) == inv_way) set_d[w] = AGE_MAX;
        else if (cur[w] > a_inv)      set_d[w] = cur[w] - 1'b1;
      end
    end
`endif
  end

  // Age storage; reset leaves way 0 as LRU in every set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET; s++) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          age_q[s][w] <= LRU_WIDTH'(ASSOCIATIVITY - 1 - w);
        end
      end
    end else if (wr_en) begin
      for (int s = 0; s < SET; s++) begin
        if (IDX_WIDTH'(s) == index_in) begin
          for (int w = 0; w < ASSOCIATIVITY; w++) begin
            age_q[s][w] <= set_d[w];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lru_unit.sv
// tb_lru_unit: scoreboard bench for lru_unit against a recency-list model.
// Covers directed scenarios plus randomized load/read traffic.
module tb_lru_unit;

  localparam int SET = 8;
  localparam int A   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] index_in = '0;
  logic [1:0] mru_in = '0;
  logic       load_in = 1'b0;
`ifdef LRU_INVALIDATE_EN
  logic       inv_in = 1'b0;
  logic [1:0] inv_way = '0;
`endif
  logic [1:0] lru_out;

  lru_unit #(.SET(SET), .ASSOCIATIVITY(A)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .index_in (index_in),
    .mru_in   (mru_in),
    .load_in  (load_in),
`ifdef LRU_INVALIDATE_EN
    .inv_in   (inv_in),
    .inv_way  (inv_way),
`endif
    .lru_out  (lru_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    exp;
    int    idx;
    string tag;
  } chk_t;

  chk_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // ord[s][0] is MRU, ord[s][A-1] is LRU
  int ord [SET][A];
  int p_ld, p_inv, p_idx, p_way, p_iway;

  task automatic model_reset();
    for (int s = 0; s < SET; s++)
      for (int k = 0; k < A; k++)
        ord[s][k] = A - 1 - k;
    p_ld = 0;
    p_inv = 0;
  endtask

  task automatic find_pos(input int s, input int w, output int p);
    p = 0;
    for (int k = 0; k < A; k++)
      if (ord[s][k] == w) p = k;
  endtask

  task automatic touch(input int s, input int w);
    int p;
    find_pos(s, w, p);
    for (int k = p; k > 0; k--) ord[s][k] = ord[s][k-1];
    ord[s][0] = w;
  endtask

  task automatic evict(input int s, input int w);
    int p;
    find_pos(s, w, p);
    for (int k = p; k < A - 1; k++) ord[s][k] = ord[s][k+1];
    ord[s][A-1] = w;
  endtask

  task automatic apply_pending();
    if (p_ld != 0) touch(p_idx, p_way);
    else if (p_inv != 0) evict(p_idx, p_iway);
    p_ld = 0;
    p_inv = 0;
  endtask

  // exp < 0: expectation comes from the model
  task automatic step(input int idx, input int ld, input int way,
                      input int inv, input int iway,
                      input int exp, input string tag);
    chk_t c;
    @(posedge clk);
    #1;
    apply_pending();
    index_in = idx[2:0];
    load_in  = (ld != 0);
    mru_in   = way[1:0];
`ifdef LRU_INVALIDATE_EN
    inv_in   = (inv != 0);
    inv_way  = iway[1:0];
    p_inv    = inv;
`endif
    p_ld   = ld;
    p_idx  = idx;
    p_way  = way;
    p_iway = iway;
    c.exp = (exp < 0) ? ord[idx][A-1] : exp;
    c.idx = idx;
    c.tag = tag;
    sbq.push_back(c);
  endtask

  // Monitor: lru_out is valid every cycle; compare mid-cycle.
  initial begin
    chk_t c;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        c = sbq.pop_front();
        n_chk++;
        if (int'(lru_out) != c.exp) begin
          n_fail++;
          $display("FAIL %s idx=%0d: lru_out=%0d expected %0d",
                   c.tag, c.idx, lru_out, c.exp);
        end
      end
    end
  end

  initial begin
    int seq3 [4];
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < SET; i++) step(i, 0, 0, 0, 0, 0, "reset");

    seq3 = '{3, 1, 2, 3};
    for (int i = 0; i < 4; i++) step(0, 1, seq3[i], 0, 0, 0, "set0_load");
    step(0, 0, 0, 0, 0, 0, "set0_after");

    step(1, 1, 0, 0, 0, 0, "set1_ld0");
    step(1, 1, 1, 0, 0, 1, "set1_ld1");
    step(1, 1, 2, 0, 0, 2, "set1_ld2");
    step(1, 1, 3, 0, 0, 3, "set1_ld3");
    step(1, 0, 0, 0, 0, 0, "set1_after");
    step(0, 0, 0, 0, 0, 0, "set0_untouched");

    step(2, 1, 0, 0, 0, 0, "set2_ld0a");
    step(2, 1, 0, 0, 0, 1, "set2_ld0b");
    step(2, 1, 2, 0, 0, 1, "set2_ld2");
    step(2, 1, 1, 0, 0, 1, "set2_ld1");
    step(2, 0, 0, 0, 0, 3, "set2_after");

    step(1, 1, 0, 0, 0, 0, "set1_pre");
    step(1, 0, 0, 0, 0, 1, "set1_pre_reset");
    #6;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (lru_out != 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: lru_out=%0d expected 0", lru_out);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, "post_reset");

`ifdef LRU_INVALIDATE_EN
    for (int i = 0; i < 4; i++) step(1, 1, i, 0, 0, -1, "inv_prep");
    step(1, 0, 0, 1, 2, 0, "inv_way2");
    step(1, 1, 0, 1, 1, 2, "inv_result");
    step(1, 0, 0, 0, 0, 2, "load_over_inv");
`endif

    for (int i = 0; i < 400; i++) begin
      int idx, ld, way, inv, iway;
      idx  = $urandom_range(SET - 1);
      ld   = ($urandom_range(9) < 7) ? 1 : 0;
      way  = $urandom_range(A - 1);
      inv  = 0;
      iway = $urandom_range(A - 1);
`ifdef LRU_INVALIDATE_EN
      inv  = ($urandom_range(3) == 0) ? 1 : 0;
`endif
      step(idx, ld, way, inv, iway, -1, "random");
    end

    @(posedge clk);
    #1;
    load_in = 1'b0;
`ifdef LRU_INVALIDATE_EN
    inv_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
